// File: rtl/uart_rx_fifo.sv
// Receive-side byte queue behind the UART RX FSM: captures data_valid strobes into a
// circular buffer, presents them first-word-fall-through, and tracks overrun drops.
module uart_rx_fifo #(
  parameter int DWIDTH     = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_THRESH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_valid,
  input  logic [DWIDTH-1:0]     p_data,
  input  logic                  rd_ready,
  input  logic                  ovr_clr,
  output logic                  rd_valid,
  output logic [DWIDTH-1:0]     rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overrun,
  output logic [7:0]            drop_count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);

  logic [DWIDTH-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  overrun_q, overrun_d;
  logic [7:0]            drop_count_q, drop_count_d;
  logic                  push, pop, drop;

  assign empty       = (level_q == '0);
  assign full        = (level_q == FULL_LVL);
  assign almost_full = (level_q >= AF_LVL);
  assign rd_valid    = !empty;
  assign rd_data     = empty ? '0 : mem_q[rd_ptr_q];
  assign level       = level_q;
  assign overrun     = overrun_q;
  assign drop_count  = drop_count_q;

  always_comb begin
    pop          = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push         = data_valid && (!full || pop);
    drop         = data_valid && full && !pop;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overrun_d    = overrun_q;
    drop_count_d = drop_count_q;
    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    if (push && !pop) level_d = level_q + LW'(1);
    if (pop && !push) level_d = level_q - LW'(1);
    if (ovr_clr) begin
      overrun_d    = 1'b0;
      drop_count_d = '0;
    end
    // Drop is applied after the clear so a coincident drop wins.
    if (drop) begin
      overrun_d = 1'b1;
      if (drop_count_d != 8'hFF) drop_count_d = drop_count_d + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overrun_q    <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overrun_q    <= overrun_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= p_data;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART RX control FSM. It captures each parallel byte on the FSM's one-cycle data_valid pulse and queues it in a DEPTH-entry circular FIFO. It presents the bytes to the host side through a first-word-fall-through valid/ready interface. It also reports fill level and status, plus sticky overrun and dropped-byte statistics.

Parameters:
DWIDTH, 8, width of one received data word (matches the deserializer output)
DEPTH_LOG2, 4, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 = 16 entries
AF_THRESH, 12, almost_full asserts when level >= AF_THRESH; legal range 1..DEPTH

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
data_valid  input  1  one-cycle strobe from RX FSM; p_data valid this cycle
p_data  input  DWIDTH  received byte from deserializer
rd_ready  input  1  consumer ready; pop occurs when rd_valid && rd_ready
ovr_clr  input  1  clears overrun and drop_count
rd_valid  output  1  FIFO non-empty; rd_data holds oldest entry
rd_data  output  DWIDTH  oldest entry; 0 when empty
level  output  DEPTH_LOG2+1  number of stored entries, 0..DEPTH
empty  output  1  level == 0
full  output  1  level == DEPTH
almost_full  output  1  level >= AF_THRESH
overrun  output  1  sticky flag: at least one byte dropped since last clear
drop_count  output  8  number of dropped bytes, saturates at 255

Behaviour:
- Reset (rst=1 at a clock edge):
  - wr_ptr=0, rd_ptr=0, level=0.
  - empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0.
  - overrun=0, drop_count=0.
  - Storage array is not reset.
  - Reset mid-operation discards all queued data; reset overrides all other inputs in that cycle.
- Pop: pop = rd_valid && rd_ready. rd_ptr advances by 1 modulo DEPTH on the next edge.
- Push: push = data_valid && (!full || pop).
  - mem[wr_ptr] <= p_data; wr_ptr advances by 1 modulo DEPTH.
  - Pointers are DEPTH_LOG2 bits and wrap naturally from DEPTH-1 to 0.
- Level update on each edge:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- Flags:
  - empty, full and almost_full are combinational decodes of the registered level.
  - rd_valid = !empty.
  - rd_data = mem[rd_ptr] when !empty, else 0.
- Latency: a byte pushed at edge N is visible on rd_valid/rd_data after edge N, i.e. in cycle N+1. With an empty FIFO, no same-cycle bypass from p_data to rd_data.
- Boundary conditions:
  - Push while empty: no pop is possible since rd_valid=0; the entry is stored and level becomes 1.
  - Push while full with pop in the same cycle: both occur, level stays DEPTH, no drop.
  - data_valid while full with no pop: byte discarded; storage and pointers unchanged.
    - overrun <= 1.
    - drop_count <= drop_count+1, saturating at 255.
  - Pop while empty: impossible (rd_valid=0); rd_ready is ignored.
- ovr_clr:
  - Clears overrun to 0 and drop_count to 0 on the next edge.
  - If a drop occurs in the same cycle, the drop wins: overrun=1, drop_count=1.
- p_data is sampled only in cycles where data_valid=1. data_valid held high for multiple cycles is treated as one push per cycle.
- rd_data stays stable while rd_valid=1 && rd_ready=0, unless rst is asserted.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> level=0, empty=1, rd_valid=0, rd_data=0, overrun=0, drop_count=0.
- Single byte: data_valid pulse with p_data=0xA5, rd_ready=0 -> next cycle rd_valid=1, rd_data=0xA5, level=1. Raise rd_ready for 1 cycle -> empty=1, level=0.
- Fill and wrap: push 16 bytes 0x00..0x0F:
  - almost_full rises when level reaches 12; full=1 at level 16.
  - Pop all 16 -> order 0x00..0x0F.
  - Push 0x10, 0x11 -> read back in order, confirming pointer wrap.
- Overrun: with full=1 and rd_ready=0, send 3 data_valid pulses (0xE0..0xE2) -> contents unchanged, overrun=1, drop_count=3.
  - ovr_clr pulse -> overrun=0, drop_count=0.
  - ovr_clr in the same cycle as a drop -> overrun=1, drop_count=1.
- Simultaneous push/pop at full: level=16, rd_ready=1 and data_valid=1 with p_data=0x77 -> level stays 16, no drop, 0x77 returned last after draining.
- Reset mid-stream: 5 entries queued, assert rst for 1 cycle -> level=0, empty=1, pointers restart. Next push 0x3C -> rd_data=0x3C.
